// File: rtl/decode_regfile_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, special register indices,
// decode-stage state encoding and an index range helper.
package decode_regfile_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {INIT, RUN} state_t;

  // True when idx names a real register of an n-entry file (RNONE never does).
  function automatic logic idx_ok(input logic [3:0] idx, input int unsigned n);
    return 32'(idx) < n;
  endfunction

endpackage

// File: rtl/decode_regfile_if.sv
// Decode request/response and write-back port bundle for decode_regfile.
interface decode_regfile_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        out_valid;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        wr_e_en;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic        wr_m_en;
  logic [3:0]  dstM;
  logic [63:0] valM;

  modport master (
    output in_valid, icode, rA, rB, wr_e_en, dstE, valE, wr_m_en, dstM, valM,
    input  in_ready, out_valid, srcA, srcB, valA, valB
  );

  modport slave (
    input  in_valid, icode, rA, rB, wr_e_en, dstE, valE, wr_m_en, dstM, valM,
    output in_ready, out_valid, srcA, srcB, valA, valB
  );
endinterface

// File: rtl/decode_regfile_src_decode.sv
// Combinational Y86-64 source-register decode (icode/rA/rB -> srcA/srcB),
// shared with the pipelined core.
module src_decode
  import decode_regfile_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] srcA,
  output logic [3:0] srcB
);

  always_comb begin
    srcA = RNONE;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: srcA = rA;
      IRET, IPOPQ:                    srcA = RRSP;
      default:                        srcA = RNONE;
    endcase
  end

  always_comb begin
    srcB = RNONE;
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:       srcB = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:   srcB = RRSP;
      default:                      srcB = RNONE;
    endcase
  end

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode-stage register file: clears all registers after reset, then
// serves registered srcA/srcB reads and write-back updates. Optional macro
// REGFILE_BYPASS_EN forwards same-edge write data to reads.
module decode_regfile
  import decode_regfile_pkg::*;
#(
  parameter int unsigned NREGS       = 15,
  parameter int unsigned INIT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  decode_regfile_if.slave  bus
);

  state_t      state;
  logic [3:0]  init_cnt;
  logic [63:0] regs [NREGS];
  logic [3:0]  dec_a;
  logic [3:0]  dec_b;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic        accept;

  src_decode u_src_decode (
    .icode (bus.icode),
    .rA    (bus.rA),
    .rB    (bus.rB),
    .srcA  (dec_a),
    .srcB  (dec_b)
  );

  assign bus.in_ready = (state == RUN);
  assign accept       = bus.in_valid && (state == RUN);

  function automatic logic [63:0] read_port(input logic [3:0] idx);
    logic [63:0] r;
    r = '0;
    if (idx_ok(idx, NREGS)) begin
      r = regs[idx];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_e_en && bus.dstE == idx) r = bus.valE;
      if (bus.wr_m_en && bus.dstM == idx) r = bus.valM;
`endif
    end
    return r;
  endfunction

  always_comb begin
    rd_a = read_port(dec_a);
    rd_b = read_port(dec_b);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= INIT;
      init_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.srcA      <= RNONE;
      bus.srcB      <= RNONE;
      bus.valA      <= '0;
      bus.valB      <= '0;
    end else begin
      bus.out_valid <= accept;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 4'd1;
          if (init_cnt == 4'(INIT_CYCLES - 1)) state <= RUN;
        end
        RUN: ;
        default: state <= INIT;
      endcase
      if (accept) begin
        bus.srcA <= dec_a;
        bus.srcB <= dec_b;
        bus.valA <= rd_a;
        bus.valB <= rd_b;
      end
    end
  end

  // M port is written last so it wins when both ports target one register.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      if (idx_ok(init_cnt, NREGS)) regs[init_cnt] <= '0;
    end else if (rst_n) begin
      if (bus.wr_e_en && idx_ok(bus.dstE, NREGS)) regs[bus.dstE] <= bus.valE;
      if (bus.wr_m_en && idx_ok(bus.dstM, NREGS)) regs[bus.dstM] <= bus.valM;
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: cycle-level reference model plus
// directed vectors with hand-computed expectations.
module tb_decode_regfile;

  localparam int unsigned NR    = 15;
  localparam int unsigned INITC = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  decode_regfile_if bus ();

  decode_regfile #(.NREGS(NR), .INIT_CYCLES(INITC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: readiness is "15 clean edges since reset", reads come from
  // an array snapshot taken before this edge's writes.
  logic [63:0] m_regs [NR];
  int unsigned m_since = 0;
  logic        m_ready = 1'b0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_srcA  = 4'hF;
  logic [3:0]  m_srcB  = 4'hF;
  logic [63:0] m_valA  = '0;
  logic [63:0] m_valB  = '0;

  function automatic logic [3:0] exp_src_a(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB:             return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] exp_src_b(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6:       return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    logic [63:0] r;
    if (idx == 4'hF) return '0;
    r = m_regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_e_en && bus.dstE == idx) r = bus.valE;
    if (bus.wr_m_en && bus.dstM == idx) r = bus.valM;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_since = 0;
      m_valid = 1'b0;
      m_srcA  = 4'hF;
      m_srcB  = 4'hF;
      m_valA  = '0;
      m_valB  = '0;
      for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    end else begin
      m_valid = 1'b0;
      if (m_since >= INITC) begin
        if (bus.in_valid) begin
          m_valid = 1'b1;
          m_srcA  = exp_src_a(bus.icode, bus.rA);
          m_srcB  = exp_src_b(bus.icode, bus.rB);
          m_valA  = m_read(m_srcA);
          m_valB  = m_read(m_srcB);
        end
        if (bus.wr_e_en && bus.dstE != 4'hF) m_regs[bus.dstE] = bus.valE;
        if (bus.wr_m_en && bus.dstM != 4'hF) m_regs[bus.dstM] = bus.valM;
      end
      if (m_since < 1000) m_since++;
    end
    m_ready = (m_since >= INITC);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  64'(bus.in_ready),  64'(m_ready));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("srcA",      64'(bus.srcA),      64'(m_srcA));
      check("srcB",      64'(bus.srcB),      64'(m_srcB));
      check("valA",      bus.valA,           m_valA);
      check("valB",      bus.valB,           m_valB);
    end
  end

  task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] a,
                      input logic [3:0] b, input logic we, input logic [3:0] de,
                      input logic [63:0] ve, input logic wm, input logic [3:0] dm,
                      input logic [63:0] vm);
    bus.in_valid = v;
    bus.icode    = ic;
    bus.rA       = a;
    bus.rB       = b;
    bus.wr_e_en  = we;
    bus.dstE     = de;
    bus.valE     = ve;
    bus.wr_m_en  = wm;
    bus.dstM     = dm;
    bus.valM     = vm;
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
    step(1'b1, ic, a, b, 1'b0, 4'hF, '0, 1'b0, 4'hF, '0);
  endtask

  task automatic idle();
    step(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 4'hF, '0, 1'b0, 4'hF, '0);
  endtask

  // Releases reset and counts negedges with in_ready low; bounded at 40.
  task automatic release_and_count(input string nm);
    int unsigned lows;
    lows  = 0;
    rst_n = 1'b1;
    while (bus.in_ready !== 1'b1 && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    check(nm, 64'(lows), 64'd15);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    idle();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_srcA", 64'(bus.srcA), 64'hF);

    // Request held and a stray write driven throughout INIT; both must be ignored.
    bus.in_valid = 1'b1; bus.icode = 4'h6; bus.rA = 4'h3; bus.rB = 4'h5;
    bus.wr_e_en  = 1'b1; bus.dstE = 4'h5; bus.valE = 64'hDEAD;
    release_and_count("init_len");
    req(4'h6, 4'h3, 4'h5);
    check("first_valid", 64'(bus.out_valid), 64'd1);
    check("first_valA", bus.valA, 64'd0);
    check("first_valB_init_write_ignored", bus.valB, 64'd0);

    step(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h3, 64'h1234, 1'b0, 4'hF, '0);
    req(4'h6, 4'h3, 4'h3);
    check("opq_srcA", 64'(bus.srcA), 64'h3);
    check("opq_srcB", 64'(bus.srcB), 64'h3);
    check("opq_valA", bus.valA, 64'h1234);
    check("opq_valB", bus.valB, 64'h1234);
    idle();
    check("pulse_valid", 64'(bus.out_valid), 64'd0);
    check("hold_valA", bus.valA, 64'h1234);

    req(4'hB, 4'h2, 4'h0);
    check("popq_srcA", 64'(bus.srcA), 64'h4);
    check("popq_srcB", 64'(bus.srcB), 64'h4);
    req(4'h3, 4'h0, 4'h0);
    check("irmovq_srcA", 64'(bus.srcA), 64'hF);
    check("irmovq_srcB", 64'(bus.srcB), 64'hF);
    check("irmovq_valA", bus.valA, 64'd0);

    step(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h4, 64'h10, 1'b1, 4'h4, 64'h20);
    req(4'h2, 4'h4, 4'h0);
    check("conflict_valM_wins", bus.valA, 64'h20);
    req(4'h8, 4'h0, 4'h0);
    check("call_srcA", 64'(bus.srcA), 64'hF);
    check("call_valB", bus.valB, 64'h20);

    step(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h1, 64'h55, 1'b0, 4'hF, '0);
    step(1'b1, 4'h2, 4'h1, 4'h0, 1'b1, 4'h1, 64'hAA, 1'b0, 4'hF, '0);
`ifdef REGFILE_BYPASS_EN
    check("same_edge_valA", bus.valA, 64'hAA);
`else
    check("same_edge_valA", bus.valA, 64'h55);
`endif
    req(4'h2, 4'h1, 4'h0);
    check("next_edge_valA", bus.valA, 64'hAA);

    step(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'hF, 64'hFFFF, 1'b1, 4'hE, 64'h77);
    req(4'h6, 4'hE, 4'hF);
    check("reg14_valA", bus.valA, 64'h77);
    check("rnone_valB", bus.valB, 64'd0);

    req(4'hA, 4'h3, 4'h0);
    check("pushq_valA", bus.valA, 64'h1234);
    check("pushq_valB", bus.valB, 64'h20);
    req(4'h9, 4'h0, 4'h0);
    rst_n = 1'b0;
    req(4'h6, 4'h3, 4'h3);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_ready", 64'(bus.in_ready), 64'd0);
    release_and_count("reinit_len");
    req(4'h6, 4'h3, 4'h1);
    check("reinit_valA", bus.valA, 64'd0);
    check("reinit_valB", bus.valB, 64'd0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
